syscall_ctrl: RTL and testbench
===============================

# syscall_ctrl

Multi-cycle syscall sequencer for the pipelined CPU.
- When a SYSCALL reaches EX, the block freezes the pipeline and runs the requested service over valid/ready handshakes to the console device.
- For input services it writes the result to $v0 through the register-file write port.
- It releases the pipeline, or on exit halts the core permanently.
- It sits beside the main decoder and consumes the decoder's `syscall` output and the `sys_op` value from ID/EX.

## Interface
Parameters:
- `SYS_OP_W`, 4: sys_op width; equals `` `SYS_OP_LENGTH ``.
- `TIMEOUT_CYC`, 1024: maximum wait cycles for a console handshake; 0 disables the timeout.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `syscall_valid`  in  1  a valid SYSCALL instruction is in EX.
- `sys_op`  in  SYS_OP_W  service code: 1 = PRINT_INT, 5 = INPUT_INT, 10 = EXIT; any other code is illegal.
- `arg`  in  32  $a0 operand (forwarded value).
- `stall`  out  1  freezes PC, IF/ID and ID/EX; injects a bubble into EX/MEM.
- `out_valid`  out  1  print request to the console.
- `out_data`  out  32  value to print.
- `out_ready`  in  1  console accepts the print request.
- `in_ready`  out  1  request for input from the console.
- `in_valid`  in  1  console has input data.
- `in_data`  in  32  input integer.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.
- `halt`  out  1  sticky core halt.
- `err_bad_op`  out  1  one-cycle pulse on an illegal sys_op.
- `err_timeout`  out  1  one-cycle pulse on a console timeout.

## Operation
States: IDLE, PRINT, READ, WB, DONE, HALTED.

Transitions out of IDLE (`syscall_valid` high):
- PRINT_INT: latch `arg` into `out_data` and go to PRINT.
- INPUT_INT: go to READ.
- EXIT: go to HALTED.
- Illegal code: pulse `err_bad_op` and go to DONE. The instruction then behaves as a NOP.

PRINT:
- `out_valid` = 1.
- On `out_valid && out_ready`, go to DONE.

READ:
- `in_ready` = 1.
- On `in_valid && in_ready`, capture `in_data` and go to WB.

WB:
- `rf_we` = 1, `rf_waddr` = 2, `rf_wdata` = captured value for exactly one cycle.
- Then go to DONE.

DONE:
- `stall` = 0 for one cycle so the SYSCALL leaves EX.
- Then go to IDLE. This prevents the same instruction from re-triggering.

HALTED:
- `halt` = 1 and `stall` = 1.
- Only reset leaves this state.

Timeout counter:
- Cleared on entry to PRINT or READ; increments each cycle the handshake does not complete.
- At `TIMEOUT_CYC`-1 with no handshake, pulse `err_timeout`.
  - From PRINT: go to DONE; the print is dropped.
  - From READ: go to WB with captured value 0.
- The counter width is clog2(TIMEOUT_CYC+1) and it saturates. It never wraps.

Stall equation: `stall` = (IDLE && `syscall_valid`) || PRINT || READ || WB || HALTED. It is combinational from `syscall_valid` in IDLE.

`out_data` is held stable while `out_valid` is high.

## Timing
Reset values (asynchronous, immediate):
- State = IDLE.
- `stall`, `out_valid`, `in_ready`, `rf_we`, `halt`, `err_*` = 0.
- `out_data`, `rf_wdata` = 0; `rf_waddr` = 2.

Reset asserted mid-handshake:
- The block returns to IDLE.
- It drops `out_valid`/`in_ready` immediately and performs no register write.

PRINT with `out_ready` already high (cycle 0 = syscall seen in IDLE):
- Cycle 0: IDLE, stall high.
- Cycle 1: PRINT, transfer occurs, stall high.
- Cycle 2: DONE, stall low.
- Cycle 3: IDLE.

INPUT with `in_valid` already high:
- Cycle 0: IDLE, stall high.
- Cycle 1: READ, capture.
- Cycle 2: WB.
- Cycle 3: DONE.
- Stall is high in cycles 0-2.

Back-to-back SYSCALLs incur exactly one unstalled cycle between services.

`in_valid` or `out_ready` asserted outside READ/PRINT is ignored.

A handshake completing in the same cycle the timeout fires counts as success; no error pulse is raised.

`halt` rises in the cycle after EXIT is seen in IDLE.

## Structure
- Shared package / `instruction_head.v`:
  - `` `SYSCALL_PRINT_INT ``, `` `SYSCALL_INPUT_INT ``, `` `SYSCALL_EXIT ``.
  - `` `REG_V0 `` (=2).
  - State encoding constants.
- Natural sub-module: `syscall_timer`, the saturating wait counter with clear, enable and expire outputs.
- Everything else lives in a single FSM module.

## Test plan
- PRINT, `arg`=0x0000002A, `out_ready` delayed 3 cycles:
  - `out_valid` held for 4 cycles with `out_data`=0x2A.
  - `stall` high for 5 cycles.
  - No `rf_we`.
- INPUT, `in_data`=0xFFFFFFF6 on the second READ cycle:
  - One-cycle `rf_we` with `rf_waddr`=2 and `rf_wdata`=0xFFFFFFF6.
  - Then a DONE cycle with `stall`=0.
- Two consecutive SYSCALLs (PRINT then INPUT):
  - Exactly one unstalled cycle between them.
  - Each service runs once; no duplicate print.
- `sys_op`=3:
  - `err_bad_op` pulses once.
  - `stall` high for 1 cycle; no console or RF activity.
- `TIMEOUT_CYC`=8, INPUT with `in_valid` never asserted:
  - `err_timeout` pulses after 8 READ cycles.
  - `rf_wdata`=0 is written to $v0.
- EXIT:
  - `halt` and `stall` stay high for 100 cycles.
  - Asserting `rst_n`=0 mid-HALTED clears both immediately.
  - The next SYSCALL is serviced normally.

Source files
------------

// File: rtl/syscall_pkg.sv
// Shared constants and types for the syscall sequencer: service codes, register
// numbers, FSM state encoding and the service decoder.
package syscall_pkg;

  localparam int unsigned SYS_OP_LENGTH     = 4;
  localparam int unsigned SYSCALL_PRINT_INT = 1;
  localparam int unsigned SYSCALL_INPUT_INT = 5;
  localparam int unsigned SYSCALL_EXIT      = 10;
  localparam int unsigned REG_V0            = 2;
  localparam int unsigned DataW             = 32;
  localparam int unsigned RegAddrW          = 5;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPrint  = 3'd1,
    StRead   = 3'd2,
    StWb     = 3'd3,
    StDone   = 3'd4,
    StHalted = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SvcPrint,
    SvcInput,
    SvcExit,
    SvcIllegal
  } svc_e;

  function automatic svc_e decode_svc(input logic [31:0] op);
    svc_e svc;
    if (op == 32'(SYSCALL_PRINT_INT)) begin
      svc = SvcPrint;
    end else if (op == 32'(SYSCALL_INPUT_INT)) begin
      svc = SvcInput;
    end else if (op == 32'(SYSCALL_EXIT)) begin
      svc = SvcExit;
    end else begin
      svc = SvcIllegal;
    end
    return svc;
  endfunction

endpackage

// File: rtl/syscall_timer.sv
// Saturating console-handshake wait counter. Expires when the count reaches
// TIMEOUT_CYC-1; a TIMEOUT_CYC of 0 never expires.
module syscall_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam bit TimeoutOn = (TIMEOUT_CYC != 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = TimeoutOn && (cnt_q == CntLast);

endmodule

// File: rtl/syscall_ctrl.sv
// Multi-cycle syscall sequencer: freezes the pipeline while a SYSCALL in EX runs
// its console service, writes $v0 for input services and halts the core on exit.
module syscall_ctrl
  import syscall_pkg::*;
#(
  parameter int unsigned SYS_OP_W    = SYS_OP_LENGTH,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                syscall_valid_i,
  input  logic [SYS_OP_W-1:0] sys_op_i,
  input  logic [DataW-1:0]    arg_i,
  output logic                stall_o,
  output logic                out_valid_o,
  output logic [DataW-1:0]    out_data_o,
  input  logic                out_ready_i,
  output logic                in_ready_o,
  input  logic                in_valid_i,
  input  logic [DataW-1:0]    in_data_i,
  output logic                rf_we_o,
  output logic [RegAddrW-1:0] rf_waddr_o,
  output logic [DataW-1:0]    rf_wdata_o,
  output logic                halt_o,
  output logic                err_bad_op_o,
  output logic                err_timeout_o
);

  state_e           state_q;
  logic             out_valid_q, in_ready_q, rf_we_q, halt_q;
  logic             err_bad_op_q, err_timeout_q;
  logic [DataW-1:0] out_data_q, rf_wdata_q;
  logic             tmr_clr, tmr_en, tmr_expire;
  logic             out_hs, in_hs;
  svc_e             svc;

  assign svc    = decode_svc(32'(sys_op_i));
  assign out_hs = (state_q == StPrint) && out_ready_i;
  assign in_hs  = (state_q == StRead) && in_valid_i;

  // Entry to PRINT/READ is only ever from IDLE, so clearing there covers it.
  assign tmr_clr = (state_q == StIdle);
  assign tmr_en  = ((state_q == StPrint) && !out_hs) || ((state_q == StRead) && !in_hs);

  syscall_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      rf_we_q       <= 1'b0;
      halt_q        <= 1'b0;
      err_bad_op_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      out_data_q    <= '0;
      rf_wdata_q    <= '0;
    end else begin
      rf_we_q       <= 1'b0;
      err_bad_op_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (syscall_valid_i) begin
            case (svc)
              SvcPrint: begin
                state_q     <= StPrint;
                out_valid_q <= 1'b1;
                out_data_q  <= arg_i;
              end
              SvcInput: begin
                state_q    <= StRead;
                in_ready_q <= 1'b1;
              end
              SvcExit: begin
                state_q <= StHalted;
                halt_q  <= 1'b1;
              end
              default: begin
                state_q      <= StDone;
                err_bad_op_q <= 1'b1;
              end
            endcase
          end
        end
        StPrint: begin
          // A handshake in the expiry cycle wins over the timeout.
          if (out_hs) begin
            state_q     <= StDone;
            out_valid_q <= 1'b0;
          end else if (tmr_expire) begin
            state_q       <= StDone;
            out_valid_q   <= 1'b0;
            err_timeout_q <= 1'b1;
          end
        end
        StRead: begin
          if (in_hs) begin
            state_q    <= StWb;
            in_ready_q <= 1'b0;
            rf_we_q    <= 1'b1;
            rf_wdata_q <= in_data_i;
          end else if (tmr_expire) begin
            state_q       <= StWb;
            in_ready_q    <= 1'b0;
            rf_we_q       <= 1'b1;
            rf_wdata_q    <= '0;
            err_timeout_q <= 1'b1;
          end
        end
        StWb:     state_q <= StDone;
        StDone:   state_q <= StIdle;
        StHalted: state_q <= StHalted;
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  // DONE leaves stall low for one cycle so the SYSCALL can move out of EX.
  assign stall_o = ((state_q == StIdle) && syscall_valid_i) ||
                   (state_q == StPrint) || (state_q == StRead) ||
                   (state_q == StWb) || (state_q == StHalted);

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign in_ready_o    = in_ready_q;
  assign rf_we_o       = rf_we_q;
  assign rf_waddr_o    = RegAddrW'(REG_V0);
  assign rf_wdata_o    = rf_wdata_q;
  assign halt_o        = halt_q;
  assign err_bad_op_o  = err_bad_op_q;
  assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_syscall_ctrl.sv
// Scoreboard bench for syscall_ctrl: directed and random services checked
// against a cycle-count model of the service rules.
module tb_syscall_ctrl;
  import syscall_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        syscall_valid;
  logic [3:0]  sys_op;
  logic [31:0] arg;
  logic        stall, out_valid, out_ready, in_ready, in_valid;
  logic [31:0] out_data, in_data, rf_wdata;
  logic        rf_we, halt, err_bad_op, err_timeout;
  logic [4:0]  rf_waddr;

  always #5 clk = ~clk;

  syscall_ctrl #(
    .SYS_OP_W   (4),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .syscall_valid_i(syscall_valid),
    .sys_op_i       (sys_op),
    .arg_i          (arg),
    .stall_o        (stall),
    .out_valid_o    (out_valid),
    .out_data_o     (out_data),
    .out_ready_i    (out_ready),
    .in_ready_o     (in_ready),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .halt_o         (halt),
    .err_bad_op_o   (err_bad_op),
    .err_timeout_o  (err_timeout)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_print[$];
  logic [31:0] exp_wr[$];
  int          pend_bad = 0;
  int          pend_to = 0;
  logic [31:0] cur_print = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) check("out_data_stable", out_data, cur_print);
        if (out_valid && out_ready) begin
          check("print_expected", 32'(exp_print.size() != 0), 32'd1);
          if (exp_print.size() != 0) check("print_data", out_data, exp_print.pop_front());
        end
        if (rf_we) begin
          check("rf_waddr", 32'(rf_waddr), 32'(REG_V0));
          check("rf_we_expected", 32'(exp_wr.size() != 0), 32'd1);
          if (exp_wr.size() != 0) check("rf_wdata", rf_wdata, exp_wr.pop_front());
        end
        if (err_bad_op) begin
          check("err_bad_op_expected", 32'(pend_bad > 0), 32'd1);
          if (pend_bad > 0) pend_bad--;
        end
        if (err_timeout) begin
          check("err_timeout_expected", 32'(pend_to > 0), 32'd1);
          if (pend_to > 0) pend_to--;
        end
      end
    end
  endtask

  // Runs one SYSCALL; the console answers after d request cycles. Returns
  // after the unstalled cycle with syscall_valid still high.
  task automatic service(input int op, input logic [31:0] a, input int d,
                         input logic [31:0] din);
    int busy_exp, stall_exp;
    int stalls = 0;
    int busy = 0;
    int reqc = 0;
    bit done = 1'b0;
    bit ok;
    ok = (d + 1 <= TO);
    busy_exp  = (op == 1 || op == 5) ? (ok ? d + 1 : TO) : 0;
    stall_exp = 1 + busy_exp + ((op == 5) ? 1 : 0);
    if (op == 1) begin
      cur_print = a;
      if (ok) exp_print.push_back(a);
      else pend_to++;
    end else if (op == 5) begin
      exp_wr.push_back(ok ? din : 32'd0);
      if (!ok) pend_to++;
    end else begin
      pend_bad++;
    end
    syscall_valid = 1'b1;
    sys_op = 4'(op);
    arg = a;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (out_valid || in_ready) begin
        reqc++;
        busy++;
      end
      out_ready = out_valid ? (reqc > d) : 1'($urandom);
      in_valid  = in_ready ? (reqc > d) : 1'($urandom);
      in_data   = (in_ready && in_valid) ? din : $urandom;
      #1;
      if (cyc == 0) check("stall_at_issue", 32'(stall), 32'd1);
      if (stall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    check("service_completes", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(stall_exp));
    check("handshake_cycles", 32'(busy), 32'(busy_exp));
  endtask

  task automatic idle(input int n);
    syscall_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      out_ready = 1'($urandom);
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      #1;
      check("idle_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bad;
    int op;
    syscall_valid = 1'b0;
    sys_op = '0;
    arg = '0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    #12;
    check("rst_ctrl", {26'd0, stall, out_valid, in_ready, rf_we, halt, err_bad_op | err_timeout},
          32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd2);
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;
    fork
      monitor();
    join_none

    service(1, 32'h0000_002A, 3, 32'd0);
    idle(2);
    service(5, 32'd0, 1, 32'hFFFF_FFF6);
    idle(1);
    service(1, 32'hDEAD_BEEF, 0, 32'd0);
    service(5, 32'd0, 0, 32'h1357_9BDF);
    idle(1);
    service(3, 32'h1111_1111, 0, 32'd0);
    idle(1);
    service(5, 32'd0, 1000, 32'hAAAA_5555);
    idle(1);
    service(1, 32'h0BAD_F00D, 1000, 32'd0);
    idle(1);
    service(1, 32'h7777_0007, TO - 1, 32'd0);
    idle(1);

    // Reset mid-handshake drops the request and performs no write.
    for (int k = 0; k < 2; k++) begin
      syscall_valid = 1'b1;
      sys_op = (k == 0) ? 4'd1 : 4'd5;
      arg = 32'h1234_5670 + 32'(k);
      cur_print = arg;
      out_ready = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pre_reset_request", 32'((k == 0) ? out_valid : in_ready), 32'd1);
      #1 rst_n = 1'b0;
      syscall_valid = 1'b0;
      #1;
      check("reset_drops_request", 32'(out_valid | in_ready | rf_we | stall), 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
    end

    // EXIT halts until reset.
    syscall_valid = 1'b1;
    sys_op = 4'd10;
    #1;
    check("exit_issue_stall", 32'(stall), 32'd1);
    check("exit_issue_halt", 32'(halt), 32'd0);
    @(posedge clk);
    #1;
    syscall_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      out_ready = 1'($urandom);
      in_valid = 1'($urandom);
      #1;
      if (!(halt && stall)) bad++;
      @(posedge clk);
      #1;
    end
    check("halted_cycles_bad", 32'(bad), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("reset_clears_halt", 32'(halt | stall), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    service(5, 32'd0, 2, 32'h0000_0063);
    idle(1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: op = 1;
        1: op = 5;
        default: begin
          do op = int'($urandom_range(0, 15)); while (op == 1 || op == 5 || op == 10);
        end
      endcase
      service(op, $urandom, int'($urandom_range(0, 10)), $urandom);
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    check("prints_outstanding", 32'(exp_print.size()), 32'd0);
    check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    check("bad_op_outstanding", 32'(pend_bad), 32'd0);
    check("timeout_outstanding", 32'(pend_to), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
